// File: rtl/video_pkg.sv
// Shared display definitions: colour cell layout, write FSM states and
// visible-area constants used by both the frame store and the sync generator.
package video_pkg;

    localparam int VGA_H_RES   = 640;
    localparam int VGA_V_RES   = 480;
    localparam int VGA_CH_BITS = 4;

    typedef struct packed {
        logic [VGA_CH_BITS-1:0] r;
        logic [VGA_CH_BITS-1:0] g;
        logic [VGA_CH_BITS-1:0] b;
    } color_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Bits needed to address 'value' entries; never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
module frame_ram
    import video_pkg::*;
#(
    parameter int DEPTH = 4800,
    parameter int WIDTH = 12,
    parameter int AW    = 13
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both updates in one block so a same-cell read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/video_frame_store.sv
// Scaled frame buffer: producer writes and hardware clear on one port,
// two-stage pixel lookup with blanking and border on the display side.
module video_frame_store
    import video_pkg::*;
#(
    parameter int H_RES       = VGA_H_RES,
    parameter int V_RES       = VGA_V_RES,
    parameter int SCALE_SHIFT = 3,
    parameter int CH_BITS     = VGA_CH_BITS,
    parameter logic [3*CH_BITS-1:0] BORDER_COLOR = '0,
    localparam int FB_W  = H_RES >> SCALE_SHIFT,
    localparam int FB_H  = V_RES >> SCALE_SHIFT,
    localparam int DEPTH = FB_W * FB_H,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = 3 * CH_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [AW-1:0]      wr_addr,
    input  logic [CW-1:0]      wr_data,
    input  logic               clear_req,
    input  logic [CW-1:0]      clear_color,
    output logic               clear_busy,
    input  logic [9:0]         px_x,
    input  logic [9:0]         px_y,
    input  logic               video_on,
    output logic [CH_BITS-1:0] vr,
    output logic [CH_BITS-1:0] vg,
    output logic [CH_BITS-1:0] vb
);

    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [10:0]   X_LIM     = 11'(FB_W << SCALE_SHIFT);
    localparam logic [10:0]   Y_LIM     = 11'(FB_H << SCALE_SHIFT);

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [CW-1:0] clr_color;

    logic          wr_in_range;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [CW-1:0] ram_wdata;

    logic [9:0]    cell_x;
    logic [9:0]    cell_y;
    logic [AW-1:0] rd_addr;
    logic          in_buf;

    logic [CW-1:0] ram_q_p1;
    logic          in_buf_p1;
    logic          vld_p1;
    logic [CW-1:0] pix_p2;

    assign wr_ready    = (state == IDLE) && !clear_req;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;

    // Clear owns the write port; producer writes past the end are swallowed.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = clr_color;
        end else if (wr_valid && wr_ready && wr_in_range) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_color  <= '0;
            clear_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        clr_color  <= clear_color;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-buffer coordinates may alias to any cell; in_buf masks them later.
    assign cell_x  = px_x >> SCALE_SHIFT;
    assign cell_y  = px_y >> SCALE_SHIFT;
    assign rd_addr = AW'(cell_y) * AW'(FB_W) + AW'(cell_x);
    assign in_buf  = ({1'b0, px_x} < X_LIM) && ({1'b0, px_y} < Y_LIM);

    frame_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (ram_q_p1)
    );

    // Stage 1: RAM read register plus the flags that travel with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_buf_p1 <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            in_buf_p1 <= in_buf;
            vld_p1    <= video_on;
        end
    end

    // Stage 2: blanking has priority over border, border over buffer data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_p2 <= '0;
        end else if (!vld_p1) begin
            pix_p2 <= '0;
        end else if (!in_buf_p1) begin
            pix_p2 <= BORDER_COLOR;
        end else begin
            pix_p2 <= ram_q_p1;
        end
    end

    assign vr = pix_p2[CW-1 -: CH_BITS];
    assign vg = pix_p2[2*CH_BITS-1 -: CH_BITS];
    assign vb = pix_p2[CH_BITS-1:0];

endmodule

// File: tb/tb_video_frame_store.sv
// Directed bench for the frame store: a default instance plus a widened
// instance whose extra columns exercise the border colour.
module tb_video_frame_store;
    import video_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [11:0] wr_data;
    logic        clear_req;
    logic [11:0] clear_color;
    logic        clear_busy;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic        video_on;
    logic [3:0]  vr, vg, vb;

    logic        wr_ready2, clear_busy2;
    logic [3:0]  vr2, vg2, vb2;
    logic        idle_bit;
    logic [12:0] idle_addr;
    logic [11:0] idle_data;

    int checks;
    int errors;

    video_frame_store dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .px_x        (px_x),
        .px_y        (px_y),
        .video_on    (video_on),
        .vr          (vr),
        .vg          (vg),
        .vb          (vb)
    );

    video_frame_store #(
        .H_RES        (644),
        .SCALE_SHIFT  (3),
        .BORDER_COLOR (12'h5A3)
    ) dut_border (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (idle_bit),
        .wr_ready    (wr_ready2),
        .wr_addr     (idle_addr),
        .wr_data     (idle_data),
        .clear_req   (idle_bit),
        .clear_color (idle_data),
        .clear_busy  (clear_busy2),
        .px_x        (px_x),
        .px_y        (px_y),
        .video_on    (video_on),
        .vr          (vr2),
        .vg          (vg2),
        .vb          (vb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [12:0] addr, input logic [11:0] data);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready addr=%0d got=%b exp=1", addr, wr_ready);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    // Present one coordinate and wait until its result is on the outputs.
    task automatic show_px(input int x, input int y, input logic on);
        @(negedge clk);
        px_x     = 10'(x);
        px_y     = 10'(y);
        video_on = on;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (clear_busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b ready=%b exp busy=0 ready=1", clear_busy, wr_ready);
        end
        checks++;
        if ({vr, vg, vb} !== 12'h000 || {vr2, vg2, vb2} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb got=%h/%h exp=000/000", {vr, vg, vb}, {vr2, vg2, vb2});
        end
    endtask

    task automatic test_write();
        do_write(13'd1, 12'h00F);
        do_write(13'd0, 12'hF00);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                show_px(x, y, 1'b1);
                checks++;
                if (vr !== 4'hF || vg !== 4'h0 || vb !== 4'h0) begin
                    errors++;
                    $display("FAIL write_px(%0d,%0d) got=%h exp=f00", x, y, {vr, vg, vb});
                end
            end
        end
        show_px(8, 0, 1'b1);
        checks++;
        if ({vr, vg, vb} !== 12'h00F) begin
            errors++;
            $display("FAIL write_cell1 got=%h exp=00f", {vr, vg, vb});
        end
    endtask

    task automatic test_blanking();
        show_px(3, 3, 1'b0);
        checks++;
        if ({vr, vg, vb} !== 12'h000) begin
            errors++;
            $display("FAIL blank got=%h exp=000", {vr, vg, vb});
        end
    endtask

    task automatic test_latency();
        int          xs [5] = '{0, 8, 0, 8, 0};
        logic        ons[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [11:0] exp[5] = '{12'hF00, 12'h00F, 12'h000, 12'h00F, 12'hF00};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if ({vr, vg, vb} !== exp[k-2]) begin
                    errors++;
                    $display("FAIL latency_step%0d got=%h exp=%h", k - 2, {vr, vg, vb}, exp[k-2]);
                end
            end
            if (k < 5) begin
                px_x     = 10'(xs[k]);
                px_y     = 10'd0;
                video_on = ons[k];
            end
        end
    endtask

    task automatic test_border();
        show_px(642, 0, 1'b1);
        checks++;
        if ({vr2, vg2, vb2} !== 12'h5A3) begin
            errors++;
            $display("FAIL border got=%h exp=5a3", {vr2, vg2, vb2});
        end
        show_px(642, 0, 1'b0);
        checks++;
        if ({vr2, vg2, vb2} !== 12'h000) begin
            errors++;
            $display("FAIL border_blank got=%h exp=000", {vr2, vg2, vb2});
        end
    endtask

    task automatic test_clear();
        int     busy_cnt;
        int     low_cnt;
        int     guard;
        color_t c;
        busy_cnt = 0;
        low_cnt  = 0;
        @(negedge clk);
        wr_valid    = 1'b1;
        wr_addr     = 13'd5;
        wr_data     = 12'hFFF;
        clear_req   = 1'b1;
        clear_color = 12'h0A0;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_pulse_ready got=%b exp=0", wr_ready);
        end
        if (wr_ready === 1'b0) low_cnt++;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        @(negedge clk);
        for (guard = 0; guard < 6000; guard++) begin
            if (!clear_busy && wr_ready) break;
            if (clear_busy) busy_cnt++;
            if (!wr_ready) low_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (guard >= 6000) begin
            errors++;
            $display("FAIL clear_timeout busy=%b ready=%b", clear_busy, wr_ready);
        end
        checks++;
        if (busy_cnt !== 4800) begin
            errors++;
            $display("FAIL clear_busy_cycles got=%0d exp=4800", busy_cnt);
        end
        checks++;
        if (low_cnt !== 4801) begin
            errors++;
            $display("FAIL clear_ready_low got=%0d exp=4801", low_cnt);
        end
        // The held write lands on the first cycle the clear is done.
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        for (int i = 0; i < 4800; i++) begin
            show_px((i % 80) * 8, (i / 80) * 8, 1'b1);
            c = (i == 5) ? 12'hFFF : 12'h0A0;
            checks++;
            if (vr !== c.r || vg !== c.g || vb !== c.b) begin
                errors++;
                $display("FAIL clear_cell%0d got=%h exp=%h", i, {vr, vg, vb}, c);
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 13'd0;
        wr_data  = 12'h123;
        px_x     = 10'd0;
        px_y     = 10'd0;
        video_on = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({vr, vg, vb} !== 12'h0A0) begin
            errors++;
            $display("FAIL collision_old got=%h exp=0a0", {vr, vg, vb});
        end
        show_px(0, 0, 1'b1);
        checks++;
        if (vr !== 4'h1 || vg !== 4'h2 || vb !== 4'h3) begin
            errors++;
            $display("FAIL collision_new got=%h exp=123", {vr, vg, vb});
        end
    endtask

    task automatic test_reset_mid_clear();
        do_write(13'd200, 12'h777);
        show_px(0, 0, 1'b1);
        @(negedge clk);
        clear_req   = 1'b1;
        clear_color = 12'h00C;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        checks++;
        if (clear_busy !== 1'b1 || {vr, vg, vb} !== 12'h00C) begin
            errors++;
            $display("FAIL midclear_pre busy=%b rgb=%h exp busy=1 rgb=00c", clear_busy, {vr, vg, vb});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clear_busy !== 1'b0 || {vr, vg, vb} !== 12'h000) begin
            errors++;
            $display("FAIL midclear_reset busy=%b rgb=%h exp busy=0 rgb=000", clear_busy, {vr, vg, vb});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_release ready=%b busy=%b exp ready=1 busy=0", wr_ready, clear_busy);
        end
        show_px(0, 0, 1'b1);
        checks++;
        if ({vr, vg, vb} !== 12'h00C) begin
            errors++;
            $display("FAIL midclear_cell0 got=%h exp=00c", {vr, vg, vb});
        end
        show_px((98 % 80) * 8, (98 / 80) * 8, 1'b1);
        checks++;
        if ({vr, vg, vb} !== 12'h00C) begin
            errors++;
            $display("FAIL midclear_cell98 got=%h exp=00c", {vr, vg, vb});
        end
        show_px((99 % 80) * 8, (99 / 80) * 8, 1'b1);
        checks++;
        if ({vr, vg, vb} !== 12'h0A0) begin
            errors++;
            $display("FAIL midclear_cell99 got=%h exp=0a0", {vr, vg, vb});
        end
        show_px((200 % 80) * 8, (200 / 80) * 8, 1'b1);
        checks++;
        if ({vr, vg, vb} !== 12'h777) begin
            errors++;
            $display("FAIL midclear_cell200 got=%h exp=777", {vr, vg, vb});
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        px_x        = 10'd5;
        px_y        = 10'd5;
        video_on    = 1'b1;
        idle_bit    = 1'b0;
        idle_addr   = '0;
        idle_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_write();
        test_blanking();
        test_latency();
        test_border();
        test_clear();
        test_collision();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_frame_store.md
# video_frame_store

Parametrised frame-buffer successor to the basic VGA colour path. It holds a scaled-down image in on-chip dual-port RAM and accepts pixel writes from a producer through a valid/ready handshake. A hardware clear sweeps the whole buffer to one colour. On the display side it converts the sync generator's pixel coordinates into registered R/G/B channel outputs, with blanking and border handling.

## Interface
- `H_RES`, default 640: visible pixels per line.
- `V_RES`, default 480: visible lines per frame.
- `SCALE_SHIFT`, default 3: each buffer cell covers 2^SCALE_SHIFT × 2^SCALE_SHIFT screen pixels.
- `CH_BITS`, default 4: bits per colour channel; cell width is 3*CH_BITS.
- `BORDER_COLOR`, default 0: colour output for in-visible-area coordinates that fall outside the buffer.
- Derived constants: FB_W = H_RES>>SCALE_SHIFT, FB_H = V_RES>>SCALE_SHIFT, DEPTH = FB_W*FB_H, AW = clog2(DEPTH).

Ports:
- `clk` in 1: single clock, pixel clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when wr_valid && wr_ready at the clock edge.
- `wr_addr` in AW: linear cell address, y*FB_W + x.
- `wr_data` in 3*CH_BITS: {R,G,B}, R in the MSBs.
- `clear_req` in 1: one-cycle pulse that starts a fill.
- `clear_color` in 3*CH_BITS: fill value, sampled on the clear_req cycle.
- `clear_busy` out 1: high while the fill is in progress.
- `px_x` in 10: current screen column.
- `px_y` in 10: current screen row.
- `video_on` in 1: high inside the visible area.
- `vr` out CH_BITS: red channel.
- `vg` out CH_BITS: green channel.
- `vb` out CH_BITS: blue channel.

## Operation
- Write FSM has two states, IDLE and CLEAR.
  - IDLE to CLEAR on clear_req. The cycle counter is loaded with 0 and clear_color is latched.
  - In CLEAR, one cell is written per cycle at the counter address. After address DEPTH-1 is written, the FSM returns to IDLE and the counter stops.
  - clear_req during CLEAR is ignored.
- wr_ready = (state==IDLE) && !clear_req. This is combinational; no write is taken on the cycle a clear starts.
- A write whose wr_addr ≥ DEPTH is accepted and discarded; memory is unchanged.
- Read path, stage 1 (registered):
  - cell address = (px_y>>SCALE_SHIFT)*FB_W + (px_x>>SCALE_SHIFT);
  - in_buf = px_x < FB_W<<SCALE_SHIFT && px_y < FB_H<<SCALE_SHIFT;
  - video_on is delayed alongside.
- Read path, stage 2 (registered):
  - !video_on_d gives 0 on all channels;
  - else !in_buf_d gives BORDER_COLOR;
  - else the RAM data is split into vr/vg/vb.
- The RAM is read-first. A read and a write to the same cell in the same cycle return the old data.
- Reset:
  - FSM goes to IDLE, counter to 0, all pipeline registers to 0;
  - vr/vg/vb = 0, clear_busy = 0, wr_ready = 1 (given clear_req = 0);
  - RAM contents are not reset.
  - Reset during CLEAR aborts the fill and leaves the buffer partially cleared.

## Timing
- Display latency is exactly 2 cycles, from px_x/px_y/video_on to vr/vg/vb. The sync generator must delay hsync/vsync by 2 cycles to stay aligned.
- A write accepted at edge N is visible to a read address presented at edge N+1 or later.
- clear_busy rises the edge after clear_req and stays high for exactly DEPTH cycles (4800 at defaults).
- The first write after a clear is accepted on the cycle clear_busy is low.
- The multiply for the cell address is by the constant FB_W; no runtime multiplier is needed.

## Structure
- Package `video_pkg`:
  - CH_BITS-based colour struct {r,g,b};
  - FSM state enum;
  - clog2 helper;
  - timing constants shared with the sync generator (H_RES, V_RES).
- Sub-module `frame_ram`: simple dual-port, one write port and one registered read port, read-first, parametrised by depth and width, inferable as block RAM.
- The top module holds the write FSM, the clear counter, the address computation and the two-stage output pipeline.

## Test plan
- Write at defaults:
  - Stimulus: after reset, write addr 0 data 12'hF00; drive px (0,0) through (7,7) with video_on = 1.
  - Response: vr=4'hF, vg=0, vb=0 two cycles after each coordinate. Pixel (8,0) returns the reset-independent RAM value at address 1, which is written beforehand as 12'h00F, so vb=4'hF.
- Blanking:
  - Stimulus: video_on = 0 with in-range coordinates.
  - Response: outputs 0 two cycles later.
- Border:
  - Stimulus: H_RES=644, SCALE_SHIFT=3, so FB_W=80; px_x=642 with video_on = 1.
  - Response: BORDER_COLOR.
- Clear:
  - Stimulus: clear_req pulse with clear_color 12'h0A0, while wr_valid is held high.
  - Response:
    - wr_ready stays 0 for the pulse cycle plus 4800 cycles;
    - clear_busy is high for 4800 cycles;
    - a sweep of all cells then reads vg=4'hA.
- Collision:
  - Stimulus: write 12'h123 to a cell while reading the same cell in the same cycle.
  - Response: old value output; next frame outputs 1,2,3.
- Reset mid-clear:
  - Stimulus: assert rst_n low at cycle 100 of a clear.
  - Response: immediately clear_busy=0 and vr/vg/vb=0. After release, wr_ready=1. Cells 0–98 hold the clear colour and cell 200 keeps its prior data.
